// File: rtl/grid_pkg.sv
// Shared types and Q7.10 coordinate helpers for the grid point sampler.
// The sampler's optional nearest-neighbour mode (SAMPLER_NEAREST_EN) uses q_round.
package grid_pkg;

    localparam int FRAC_W     = 10;
    localparam int COORD_W    = 17;
    localparam int INT_W      = COORD_W - FRAC_W;
    localparam int Q_ONE      = 1024;
    localparam int ROUND_HALF = 512;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_RDW,
        S_IH,
        S_IV,
        S_OUT
    } sampler_state_t;

    // Integer part is one bit wider than INT_W so that rounding up to +64 still fits.
    typedef struct packed {
        logic [INT_W:0]    ipart;
        logic [FRAC_W-1:0] frac;
    } q_split_t;

    function automatic q_split_t q_floor_frac(input logic [COORD_W-1:0] v);
        q_split_t s;
        s.ipart = {v[COORD_W-1], v[COORD_W-1:FRAC_W]};
        s.frac  = v[FRAC_W-1:0];
        return s;
    endfunction

    function automatic logic [INT_W:0] q_round(input logic [COORD_W-1:0] v);
        logic [COORD_W:0] sum;
        sum = {v[COORD_W-1], v} + (COORD_W+1)'(ROUND_HALF);
        return sum[COORD_W:FRAC_W];
    endfunction

endpackage

// File: rtl/bilerp_dp.sv
// Two-stage registered bilinear datapath: horizontal blend of both rows, then vertical
// blend with round-half-up and saturation to the pixel range.
module bilerp_dp
    import grid_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_en,
    input  logic              v_en,
    input  logic [PIX_W-1:0]  p00,
    input  logic [PIX_W-1:0]  p10,
    input  logic [PIX_W-1:0]  p01,
    input  logic [PIX_W-1:0]  p11,
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    output logic [PIX_W-1:0]  pix
);

    localparam int WT_W  = FRAC_W + 1;
    localparam int H_W   = PIX_W + 11;
    localparam int ACC_W = H_W + WT_W + 1;

    logic [WT_W-1:0]   w_fx_n, w_fy_n;
    logic [H_W-1:0]    w_top, w_bot, r_top, r_bot;
    logic [ACC_W-1:0]  w_acc;
    logic [ACC_W-2*FRAC_W-1:0] w_shift;
    logic [PIX_W-1:0]  w_sat, r_pix;

    assign w_fx_n  = WT_W'(Q_ONE) - WT_W'(fx);
    assign w_fy_n  = WT_W'(Q_ONE) - WT_W'(fy);
    assign w_top   = H_W'(p00) * H_W'(w_fx_n) + H_W'(p10) * H_W'(fx);
    assign w_bot   = H_W'(p01) * H_W'(w_fx_n) + H_W'(p11) * H_W'(fx);
    assign w_acc   = ACC_W'(r_top) * ACC_W'(w_fy_n) + ACC_W'(r_bot) * ACC_W'(fy)
                   + ACC_W'(1 << (2*FRAC_W - 1));
    assign w_shift = w_acc[ACC_W-1:2*FRAC_W];
    assign w_sat   = (w_shift > (ACC_W-2*FRAC_W)'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : w_shift[PIX_W-1:0];

    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_top <= '0;
            r_bot <= '0;
            r_pix <= '0;
        end else begin
            if (h_en) begin
                r_top <= w_top;
                r_bot <= w_bot;
            end
            if (v_en) begin
                r_pix <= w_sat;
            end
        end
    end

    assign pix = r_pix;

endmodule

// File: rtl/grid_point_sampler.sv
// Point-stream consumer: fetches the 2x2 neighbourhood of each Q7.10 point and emits one pixel.
// Define SAMPLER_NEAREST_EN for single-read nearest-neighbour sampling instead of bilinear.
module grid_point_sampler
    import grid_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic               pt_last,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [PIX_W-1:0]   pix_data,
    output logic               pix_oob,
    output logic               pix_last,
    output logic               busy
);

    localparam int CRD_W = INT_W + 1;

    sampler_state_t    r_state, w_next_state;
    logic [CRD_W-1:0]  w_xi, w_yi, w_x1, w_y1;
    logic [FRAC_W-1:0] w_fx, w_fy;
    logic              w_oob, w_accept;
    logic [CRD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
    logic [FRAC_W-1:0] r_fx, r_fy;
    logic              r_oob, r_last;
    logic [PIX_W-1:0]  r_p00, r_p10, r_p01, r_p11, w_pix_src;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CRD_W-1:0] x, input logic [CRD_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

`ifdef SAMPLER_NEAREST_EN
    assign w_xi = q_round(pt_x);
    assign w_yi = q_round(pt_y);
    assign w_fx = '0;
    assign w_fy = '0;
`else
    q_split_t w_xs, w_ys;
    assign w_xs = q_floor_frac(pt_x);
    assign w_ys = q_floor_frac(pt_y);
    assign w_xi = w_xs.ipart;
    assign w_yi = w_ys.ipart;
    assign w_fx = w_xs.frac;
    assign w_fy = w_ys.frac;
`endif

    // Negative coordinates read as large unsigned values, so one compare per axis covers both bounds.
    assign w_oob    = (w_xi > CRD_W'(IMG_W - 1)) || (w_yi > CRD_W'(IMG_H - 1));
    assign w_x1     = (w_xi >= CRD_W'(IMG_W - 1)) ? w_xi : w_xi + 1'b1;
    assign w_y1     = (w_yi >= CRD_W'(IMG_H - 1)) ? w_yi : w_yi + 1'b1;
    assign w_accept = (r_state == S_IDLE) && pt_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (pt_valid) w_next_state = S_ADDR;
            S_ADDR: w_next_state = r_oob ? S_OUT : S_RD0;
`ifdef SAMPLER_NEAREST_EN
            S_RD0:  w_next_state = S_RDW;
            S_RDW:  w_next_state = S_OUT;
`else
            S_RD0:  w_next_state = S_RD1;
            S_RD1:  w_next_state = S_RD2;
            S_RD2:  w_next_state = S_RD3;
            S_RD3:  w_next_state = S_RDW;
            S_RDW:  w_next_state = S_IH;
            S_IH:   w_next_state = S_IV;
            S_IV:   w_next_state = S_OUT;
`endif
            S_OUT:  if (pix_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x0   <= '0;
            r_y0   <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_fx   <= '0;
            r_fy   <= '0;
            r_oob  <= 1'b0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_x0   <= w_xi;
            r_y0   <= w_yi;
            r_x1   <= w_x1;
            r_y1   <= w_y1;
            r_fx   <= w_fx;
            r_fy   <= w_fy;
            r_oob  <= w_oob;
            r_last <= pt_last;
        end
    end

    // Read data lags its strobe by one cycle, so each state captures the previous state's read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p00 <= '0;
            r_p10 <= '0;
            r_p01 <= '0;
            r_p11 <= '0;
        end else begin
            case (r_state)
                S_RD1: r_p00 <= mem_rdata;
                S_RD2: r_p10 <= mem_rdata;
                S_RD3: r_p01 <= mem_rdata;
`ifdef SAMPLER_NEAREST_EN
                S_RDW: r_p00 <= mem_rdata;
`else
                S_RDW: r_p11 <= mem_rdata;
`endif
                default: ;
            endcase
        end
    end

`ifdef SAMPLER_NEAREST_EN
    assign w_pix_src = r_p00;
`else
    bilerp_dp #(
        .PIX_W (PIX_W)
    ) u_bilerp_dp (
        .clk   (clk),
        .reset (reset),
        .h_en  (r_state == S_IH),
        .v_en  (r_state == S_IV),
        .p00   (r_p00),
        .p10   (r_p10),
        .p01   (r_p01),
        .p11   (r_p11),
        .fx    (r_fx),
        .fy    (r_fy),
        .pix   (w_pix_src)
    );
`endif

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (r_state)
            S_RD0: begin mem_rd_en = 1'b1; mem_addr = pix_addr(r_x0, r_y0); end
            S_RD1: begin mem_rd_en = 1'b1; mem_addr = pix_addr(r_x1, r_y0); end
            S_RD2: begin mem_rd_en = 1'b1; mem_addr = pix_addr(r_x0, r_y1); end
            S_RD3: begin mem_rd_en = 1'b1; mem_addr = pix_addr(r_x1, r_y1); end
            default: ;
        endcase
        pt_ready  = (r_state == S_IDLE) && reset;
        busy      = (r_state != S_IDLE);
        pix_valid = (r_state == S_OUT);
        pix_oob   = (r_state == S_OUT) && r_oob;
        pix_last  = (r_state == S_OUT) && r_last;
        pix_data  = ((r_state == S_OUT) && !r_oob) ? w_pix_src : '0;
    end

endmodule
